// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Combinational 1-bit full adder cell used by serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, registered carry, WIDTH+1 cycle latency.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-2:0] res_r;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;

  // Operand conditioning at load: subtract inverts b and forces the carry-in.
  always_comb begin
    b_load_s = b;
    c_load_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_s = ~b;
      c_load_s = 1'b1;
    end else begin
      b_load_s = b;
      c_load_s = cin;
    end
`endif
  end

  fa_cell u_fa (
    .a     (a_r[0]),
    .b     (b_r[0]),
    .c     (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  // The result register holds the WIDTH-1 bits already produced; the cell supplies the MSB.
  assign res_next_s = {fa_sum_s, res_r};

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {(WIDTH-1){1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= S_SHIFT;
            a_r     <= a;
            b_r     <= b_load_s;
            carry_r <= c_load_s;
            res_r   <= {(WIDTH-1){1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_r     <= {1'b0, a_r[WIDTH-1:1]};
          b_r     <= {1'b0, b_r[WIDTH-1:1]};
          carry_r <= fa_carry_s;
          res_r   <= res_next_s[WIDTH-1:1];
          // Counter holds on the final bit so it never wraps for power-of-two widths.
          if (cnt_r == LAST_CNT) begin
            state_r <= S_DONE;
            sum_r   <= res_next_s;
            cout_r  <= fa_carry_s;
            done_r  <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, hand-written corner sequences, random vs. model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int bad;
  int done_cnt;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t tbl[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; subtraction reports "no borrow" as cout.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    int r;
    if (ms) begin
      r = (int'(ma) - int'(mb)) & ((1 << W) - 1);
      return {(ma >= mb) ? 1'b1 : 1'b0, r[W-1:0]};
    end else begin
      r = int'(ma) + int'(mb) + int'(mc);
      return r[W:0];
    end
  endfunction

  // One complete operation from IDLE; returns in IDLE after busy drops.
  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts,
                       input logic [W-1:0] es, input logic ec);
    int lat;
    string lbl;
    lbl = $sformatf("%s(s%0b)", nm, ts);
    a = ta; b = tb; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom;
    chk({lbl, " busy"}, busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      chk({lbl, " sum_hold"}, (done === 1'b0) ? 1 : 0, 1);
      step();
      lat++;
    end
    chk({lbl, " latency"}, lat, W);
    chk({lbl, " sum"}, sum, es);
    chk({lbl, " cout"}, cout, ec);
    step();
    chk({lbl, " done_low"}, done, 0);
    chk({lbl, " busy_low"}, busy, 0);
  endtask

  initial begin
    int lat;
    int snap;
    logic [W:0] r;
    logic       hold_ok;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    total = 0; bad = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    tbl.push_back('{8'h35, 8'h0A, 1'b0, 1'b0, 8'h3F, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0});
    tbl.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    tbl.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
    tbl.push_back('{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1});
`endif
    foreach (tbl[i]) begin
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
            tbl[i].exp_sum, tbl[i].exp_cout);
    end

    // start pulsed mid-SHIFT is ignored; exactly one done pulse.
    snap = done_cnt;
    a = 8'h35; b = 8'h0A; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 8'h11; b = 8'h11; start = 1'b1;
    step();
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin step(); lat++; end
    chk("ignore latency", lat, W);
    chk("ignore sum", sum, 8'h3F);
    for (int i = 0; i < W + 4; i++) step();
    chk("ignore one_pulse", done_cnt - snap, 1);
    chk("ignore idle", busy, 0);

    // start held through DONE: second op accepted on first IDLE cycle; sum holds meanwhile.
    a = 8'h35; b = 8'h0A; cin = 1'b0; start = 1'b1;
    step();
    a = 8'hFF; b = 8'hFF;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin step(); lat++; end
    chk("held op1 sum", sum, 8'h3F);
    step();
    chk("held idle gap", busy, 0);
    step();
    start = 1'b0;
    chk("held op2 busy", busy, 1);
    hold_ok = 1'b1;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (sum !== 8'h3F) hold_ok = 1'b0;
      step();
      lat++;
    end
    chk("hold sum during shift", hold_ok, 1);
    chk("held op2 latency", lat, W);
    chk("held op2 sum", sum, 8'hFE);
    chk("held op2 cout", cout, 1);
    step();

    // Asynchronous reset in the middle of SHIFT discards the operation.
    snap = done_cnt;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) step();
    chk("midrst no_done", done_cnt - snap, 0);
    chk("midrst idle", busy, 0);
    do_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
`ifdef SERIAL_ADDER_SUB_EN
      rs = $urandom;
`else
      rs = 1'b0;
`endif
      r = model(ra, rb, rc, rs);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, r[W-1:0], r[W]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
